jk_excite_driver: RTL

Drives the J/K excitation inputs of a WIDTH-bit bank of JK flip-flops so that the bank reaches a requested target word. It accepts a target over a valid/ready handshake and computes per-bit excitation from the bank's fed-back Q. It pulses J/K for exactly one clock, waits for the bank to settle, and checks the result. It retries on mismatch and reports done or error. The block sits between a controller and any JK register bank in the datapath.

---
 rtl/jk_excite_driver.sv | 107 ++++++++++
 1 files changed

// File: rtl/jk_excite_driver.sv
// Drives J/K excitation for a JK flip-flop bank toward a requested target word,
// then checks the fed-back Q after a settle window and retries on mismatch.
module jk_excite_driver #(
    parameter int WIDTH     = 8,
    parameter int SETTLE    = 1,
    parameter int MAX_RETRY = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tgt_valid,
    input  logic [WIDTH-1:0] tgt_data,
    output logic             tgt_ready,
    input  logic [WIDTH-1:0] q_fb,
    output logic [WIDTH-1:0] j,
    output logic [WIDTH-1:0] k,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] mismatch
);

    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam int SW = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
    localparam logic [RW-1:0] RETRY_LIMIT = RW'(MAX_RETRY);
    localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] target;
    logic [RW-1:0]    retry_cnt;
    logic [SW-1:0]    settle_cnt;

    // Handshake: a target transfers on a rising edge where tgt_valid and
    // tgt_ready are both high; tgt_ready is only high while IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            target     <= '0;
            retry_cnt  <= '0;
            settle_cnt <= '0;
            j          <= '0;
            k          <= '0;
            done       <= 1'b0;
            err        <= 1'b0;
            tgt_ready  <= 1'b0;
            mismatch   <= '0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    tgt_ready <= 1'b1;
                    if (tgt_valid && tgt_ready) begin
                        target    <= tgt_data;
                        retry_cnt <= '0;
                        tgt_ready <= 1'b0;
                        mismatch  <= '0;
                        // Minimal excitation: set only bits that must rise, reset
                        // only bits that must fall; never the toggle code.
                        j         <= ~q_fb & tgt_data;
                        k         <= q_fb & ~tgt_data;
                        state     <= DRIVE;
                    end
                end
                DRIVE: begin
                    j          <= '0;
                    k          <= '0;
                    settle_cnt <= SETTLE_LOAD;
                    state      <= WAIT;
                end
                WAIT: begin
                    if (settle_cnt <= SW'(1)) begin
                        settle_cnt <= '0;
                        if (q_fb == target) begin
                            done      <= 1'b1;
                            mismatch  <= '0;
                            tgt_ready <= 1'b1;
                            state     <= IDLE;
                        end else if (retry_cnt < RETRY_LIMIT) begin
                            retry_cnt <= retry_cnt + RW'(1);
                            j         <= ~q_fb & target;
                            k         <= q_fb & ~target;
                            state     <= DRIVE;
                        end else begin
                            err       <= 1'b1;
                            mismatch  <= q_fb ^ target;
                            tgt_ready <= 1'b1;
                            state     <= IDLE;
                        end
                    end else begin
                        settle_cnt <= settle_cnt - SW'(1);
                    end
                end
                default: begin
                    j     <= '0;
                    k     <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
